requant_pack: RTL and testbench

REQUANT_PACK -- requirements
Module: requant_pack

---
 rtl/requant_pkg.sv | 32 +++
 rtl/requant_lane.sv | 31 +++
 rtl/requant_pack.sv | 191 +++++++++++++++++++
 tb/tb_requant_pack.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
// Shared widths and the int8 saturation helper for the requantise/pack datapath.
// Pure declarations; no latency of its own.
// No flow control here; consumers own backpressure.
package requant_pkg;

  localparam int LANES  = 8;
  localparam int ACC_W  = 32;
  localparam int SB_AW  = 9;
  localparam int OUT_W  = 8;
  localparam int PROD_W = 41;

  // Rounding needs one guard bit above the product, the bias add one more.
  localparam int RND_W  = PROD_W + 1;
  localparam int SUM_W  = PROD_W + 2;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(127);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-128);

  // Clamp a wide signed value into the int8 range.
  function automatic logic [OUT_W-1:0] sat_int8(input logic signed [SUM_W-1:0] v);
    logic [OUT_W-1:0] r;
    if (v > SAT_MAX) begin
      r = 8'h7F;
    end else if (v < SAT_MIN) begin
      r = 8'h80;
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of requantisation: round-half-up shift, bias add, int8 saturation.
// Purely combinational; the parent registers the result.
// No flow control; the parent stall freezes the inputs.
module requant_lane
  import requant_pkg::*;
(
  input  logic signed [PROD_W-1:0] prod_i,
  input  logic signed [OUT_W-1:0]  bias_i,
  input  logic        [4:0]        shift_i,
  output logic        [OUT_W-1:0]  q_o
);

  logic signed [RND_W-1:0] rnd_inc;
  logic signed [RND_W-1:0] sum_rnd;
  logic signed [RND_W-1:0] shifted;
  logic signed [SUM_W-1:0] biased;

  // Add half an output LSB, shift arithmetically, then add the bias and clamp.
  always_comb begin
    rnd_inc = '0;
    if (shift_i != 5'd0) begin
      rnd_inc = RND_W'(1) << (shift_i - 5'd1);
    end
    sum_rnd = {prod_i[PROD_W-1], prod_i} + rnd_inc;
    shifted = sum_rnd >>> shift_i;
    biased  = {shifted[RND_W-1], shifted}
            + {{(SUM_W-OUT_W){bias_i[OUT_W-1]}}, bias_i};
    q_o     = sat_int8(biased);
  end

endmodule

// File: rtl/requant_pack.sv
// Requantises per-channel int32 accumulator beats to packed int8 using an external scale/bias RAM.
// Latency: 3 cycles from input accept to m_valid; sustains one beat per cycle.
// Backpressure: one global stall (m_valid & ~m_ready) freezes every stage, s_ready and the RAM read enable.
module requant_pack #(
  parameter int LANES = 8,
  parameter int ACC_W = 32,
  parameter int SB_AW = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [LANES*ACC_W-1:0]   s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [LANES*8-1:0]       m_data,
  output logic                     m_last,
  output logic [SB_AW-1:0]         sb_addr,
  output logic                     sb_en,
  input  logic [15:0]              sb_data,
  input  logic [9:0]               out_channel,
  input  logic [4:0]               shift,
  input  logic [31:0]              total_beats,
  output logic                     busy
);

  import requant_pkg::*;

  localparam int CH_W = 10;

  logic                           stall;
  logic                           adv;
  logic                           accept;
  logic                           beat_last;

  logic [CH_W-1:0]                ch_q, ch_d;
  logic [31:0]                    beat_q, beat_d;

  // S1: captured input beat and its channel (drives the RAM address)
  logic                           s1_vld_q;
  logic [LANES*ACC_W-1:0]         s1_dat_q;
  logic [SB_AW-1:0]               s1_ch_q;
  logic                           s1_last_q;

  // S2: accumulators wait here while the RAM returns scale/bias
  logic                           s2_vld_q;
  logic [LANES*ACC_W-1:0]         s2_dat_q;
  logic                           s2_last_q;

  // S3: scaled products and the channel bias
  logic                           s3_vld_q;
  logic signed [PROD_W-1:0]       s3_prod_q [LANES];
  logic signed [OUT_W-1:0]        s3_bias_q;
  logic                           s3_last_q;

  logic signed [PROD_W-1:0]       prod_d [LANES];
  logic [LANES*OUT_W-1:0]         lane_res;

  // OUT: registered result
  logic                           m_valid_q;
  logic                           m_last_q;
  logic [LANES*OUT_W-1:0]         m_data_q;

  // Global stall: only the output register can refuse to move.
  always_comb begin
    stall     = m_valid_q & ~m_ready;
    adv       = ~stall;
    accept    = s_valid & adv;
    beat_last = (beat_q == total_beats - 32'd1);
  end

  assign s_ready = adv;
  assign sb_en   = adv;
  assign sb_addr = s1_ch_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;
  assign busy    = s1_vld_q | s2_vld_q | s3_vld_q | m_valid_q;

  // Channel and beat counters; the frame's final beat restarts both.
  always_comb begin
    ch_d   = ch_q;
    beat_d = beat_q;
    if (accept) begin
      if (beat_last) begin
        ch_d   = '0;
        beat_d = '0;
      end else begin
        beat_d = beat_q + 32'd1;
        ch_d   = (ch_q >= out_channel - CH_W'(1)) ? '0 : ch_q + CH_W'(1);
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q   <= '0;
      beat_q <= '0;
    end else begin
      ch_q   <= ch_d;
      beat_q <= beat_d;
    end
  end

  // S1 register: capture the accepted beat with its channel and last flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      s1_ch_q   <= '0;
      s1_last_q <= 1'b0;
    end else if (adv) begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_dat_q  <= s_data;
        s1_ch_q   <= SB_AW'(ch_q);
        s1_last_q <= beat_last;
      end
    end
  end

  // S2 register: the RAM read issued from S1 lands on sb_data alongside this stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_dat_q  <= '0;
      s2_last_q <= 1'b0;
    end else if (adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_q  <= s1_dat_q;
        s2_last_q <= s1_last_q;
      end
    end
  end

  // Signed accumulator times unsigned scale, both widened to the product width.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = $signed(PROD_W'($signed(s2_dat_q[i*ACC_W +: ACC_W])))
                * $signed(PROD_W'(sb_data[15:8]));
    end
  end

  // S3 register: products and bias for the lane units.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_vld_q  <= 1'b0;
      s3_last_q <= 1'b0;
      s3_bias_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        s3_prod_q[i] <= '0;
      end
    end else if (adv) begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        s3_last_q <= s2_last_q;
        s3_bias_q <= sb_data[7:0];
        for (int i = 0; i < LANES; i++) begin
          s3_prod_q[i] <= prod_d[i];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane u_lane (
      .prod_i  (s3_prod_q[g]),
      .bias_i  (s3_bias_q),
      .shift_i (shift),
      .q_o     (lane_res[g*OUT_W +: OUT_W])
    );
  end

  // Output register: m_last is qualified by valid so it never lingers on an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (adv) begin
      m_valid_q <= s3_vld_q;
      m_last_q  <= s3_vld_q & s3_last_q;
      if (s3_vld_q) begin
        m_data_q <= lane_res;
      end
    end
  end

endmodule

// File: tb/tb_requant_pack.sv
`timescale 1ns/1ps
module tb_requant_pack;

  localparam int LANES = 8;
  localparam int ACC_W = 32;
  localparam int SB_AW = 9;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   s_valid;
  logic                   s_ready;
  logic [LANES*ACC_W-1:0] s_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [LANES*8-1:0]     m_data;
  logic                   m_last;
  logic [SB_AW-1:0]       sb_addr;
  logic                   sb_en;
  logic [15:0]            sb_data;
  logic [9:0]             out_channel;
  logic [4:0]             shift;
  logic [31:0]            total_beats;
  logic                   busy;

  requant_pack #(.LANES(LANES), .ACC_W(ACC_W), .SB_AW(SB_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .sb_addr     (sb_addr),
    .sb_en       (sb_en),
    .sb_data     (sb_data),
    .out_channel (out_channel),
    .shift       (shift),
    .total_beats (total_beats),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Scale/bias RAM: registered read, output only moves when enabled.
  logic [15:0] sb_mem [2**SB_AW];
  always @(posedge clk) if (sb_en === 1'b1) sb_data <= sb_mem[sb_addr];

  typedef struct {
    logic [LANES*8-1:0] data;
    bit                 last;
    int                 id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   n_out    = 0;
  int   n_pushed = 0;
  int   k_beat   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic on the documented rounding rule.
  function automatic logic [7:0] ref_lane(input longint acc, input int scale, input int bias, input int sh);
    longint p;
    p = acc * longint'(scale);
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    p = p + longint'(bias);
    if (p > 127) p = 127;
    else if (p < -128) p = -128;
    return p[7:0];
  endfunction

  function automatic logic [LANES*ACC_W-1:0] gen_beat(input int mode, input logic [31:0] cval);
    logic [LANES*ACC_W-1:0] d;
    logic [31:0] b;
    for (int l = 0; l < LANES; l++) begin
      b = $urandom;
      if (mode == 0) d[l*ACC_W +: ACC_W] = cval;
      else begin
        case ($urandom_range(0, 2))
          0:       d[l*ACC_W +: ACC_W] = b;
          1:       d[l*ACC_W +: ACC_W] = {{20{b[11]}}, b[11:0]};
          default: d[l*ACC_W +: ACC_W] = {{11{b[20]}}, b[20:0]};
        endcase
      end
    end
    return d;
  endfunction

  // Channel of the k-th beat since reset: position in frame, modulo channel count.
  task automatic push_expected(input logic [LANES*ACC_W-1:0] d, output int ch);
    exp_t e;
    int idx;
    logic [15:0] w;
    idx = k_beat % int'(total_beats);
    ch  = idx % int'(out_channel);
    w   = sb_mem[ch];
    for (int l = 0; l < LANES; l++) begin
      e.data[l*8 +: 8] = ref_lane(longint'($signed(d[l*ACC_W +: ACC_W])), int'(w[15:8]),
                                  int'($signed(w[7:0])), int'(shift));
    end
    e.last = (idx == int'(total_beats) - 1);
    e.id   = n_pushed;
    n_pushed++;
    k_beat++;
    exp_q.push_back(e);
  endtask

  // Monitor: handshake decided at the coming edge, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected output: m_data %h with nothing outstanding", m_data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("beat%0d data", e.id), m_data, e.data);
          check($sformatf("beat%0d last", e.id), 64'(m_last), 64'(e.last));
        end
      end
    end
  end

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    if (chk) begin
      check("rst m_valid", 64'(m_valid), 0);
      check("rst m_last",  64'(m_last),  0);
      check("rst m_data",  m_data,       0);
      check("rst sb_addr", 64'(sb_addr), 0);
      check("rst busy",    64'(busy),    0);
      check("rst s_ready", 64'(s_ready), 1);
      check("rst sb_en",   64'(sb_en),   1);
    end
    exp_q.delete();
    k_beat = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_stream(input int n, input int mode, input logic [31:0] cval,
                             input int stall_at, input int stall_len, input bit rnd);
    int i = 0;
    int cyc = 0;
    int budget = n * 30 + 100;
    int ch;
    bit acc_now;
    bit in_win;
    logic [LANES*ACC_W-1:0] cur;
    cur = gen_beat(mode, cval);
    while (i < n && cyc < budget) begin
      @(negedge clk);
      in_win = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      if (rnd) begin
        s_valid = ($urandom_range(0, 3) != 0);
        m_ready = ($urandom_range(0, 3) != 0);
      end else begin
        s_valid = 1'b1;
        m_ready = !in_win;
      end
      s_data = cur;
      #1;
      if (stall_len > 0) begin
        check($sformatf("s_ready cyc%0d", cyc), 64'(s_ready), 64'(!in_win));
        check($sformatf("sb_en cyc%0d", cyc),   64'(sb_en),   64'(!in_win));
      end
      acc_now = s_valid && (s_ready === 1'b1);
      @(posedge clk);
      if (acc_now) begin
        push_expected(cur, ch);
        #1;
        check($sformatf("sb_addr beat%0d", n_pushed - 1), 64'(sb_addr), 64'(ch));
        i++;
        cur = gen_beat(mode, cval);
      end
      cyc++;
    end
    if (i < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL send timeout: %0d of %0d beats accepted", i, n);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d beats never emerged", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check("idle busy", 64'(busy), 0);
  endtask

  initial begin
    int n_before;
    rst         = 1'b1;
    s_valid     = 1'b0;
    s_data      = '0;
    m_ready     = 1'b1;
    out_channel = 10'd1;
    shift       = 5'd6;
    total_beats = 32'd1000;
    for (int a = 0; a < 2**SB_AW; a++) sb_mem[a] = 16'($urandom);

    // Known answer: 1000*3=3000, +32 -> 3032>>6=47, +5 = 52.
    sb_mem[0] = {8'd3, 8'd5};
    do_reset(1'b1);
    send_stream(2, 0, 32'd1000, 0, 0, 1'b0);
    drain();

    // Saturation both ways.
    shift = 5'd0;
    sb_mem[0] = {8'd255, 8'd0};
    do_reset(1'b0);
    send_stream(1, 0, 32'h7FFF_FFFF, 0, 0, 1'b0);
    send_stream(1, 0, 32'hFFFE_7960, 0, 0, 1'b0);
    drain();

    // Round-half-up of negative and positive halves.
    shift = 5'd1;
    sb_mem[0] = {8'd1, 8'd0};
    do_reset(1'b0);
    send_stream(1, 0, 32'hFFFF_FFFD, 0, 0, 1'b0);
    send_stream(1, 0, 32'd3, 0, 0, 1'b0);
    drain();

    // Channel rotation over three channels, back to back.
    out_channel = 10'd3;
    shift = 5'd4;
    sb_mem[0] = {8'd17, 8'hF0};
    sb_mem[1] = {8'd200, 8'd9};
    sb_mem[2] = {8'd1, 8'h80};
    do_reset(1'b0);
    send_stream(7, 1, 32'd0, 0, 0, 1'b0);
    drain();

    // Five-cycle backpressure in a 20-beat stream.
    shift = 5'd8;
    do_reset(1'b0);
    send_stream(20, 1, 32'd0, 8, 5, 1'b0);
    drain();

    // Frame of 4: last on beats 4 and 8, channel restarts on beat 5.
    out_channel = 10'd384;
    total_beats = 32'd4;
    shift = 5'd10;
    do_reset(1'b0);
    send_stream(8, 1, 32'd0, 0, 0, 1'b0);
    drain();

    // Reset lands where beat 6 would be accepted; nothing may follow.
    send_stream(5, 1, 32'd0, 0, 0, 1'b0);
    do_reset(1'b1);
    n_before = n_out;
    repeat (10) @(negedge clk);
    check("outputs after reset", 64'(n_out - n_before), 0);

    // Random traffic with random handshakes on both sides.
    for (int r = 0; r < 3; r++) begin
      out_channel = 10'd5;
      total_beats = 32'd7;
      shift = 5'($urandom_range(0, 24));
      do_reset(1'b0);
      send_stream(40, 1, 32'd0, 0, 0, 1'b1);
      drain();
    end

    // Single-beat frames: every beat is last and on channel 0.
    total_beats = 32'd1;
    shift = 5'd3;
    do_reset(1'b0);
    send_stream(10, 1, 32'd0, 0, 0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
